image_stream_proc: RTL and testbench
====================================

IMAGE_STREAM_PROC -- requirements
Module: image_stream_proc

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 960, meaning image width in pixels; each line is sent as WIDTH/2 output beats.
- REQ-002: The block SHALL have parameter HEIGHT, default 540, meaning the number of lines per frame.
- REQ-003: The block SHALL have parameter VS_DELAY, default 100, meaning the number of cycles ctrl_vsync stays high at frame start.
- REQ-004: The block SHALL have parameter HS_GAP, default 160, meaning the number of idle cycles before each line.
- REQ-005: The block SHALL have parameter MODE (2 bits), default 1, meaning 0 pass-through, 1 saturating add, 2 saturating subtract, 3 invert.
- REQ-006: The block SHALL have parameter VALUE, default 100, meaning the 8-bit operand for modes 1 and 2.
- REQ-007: The block SHALL have parameter FIFO_DEPTH, default 4, meaning input buffer entries (a power of two, at least 2).
- REQ-008: HCLK  input  1  is the single clock; every flop SHALL sample on its rising edge.
- REQ-009: HRESETn  input  1  is the reset; it SHALL be asynchronous and active-low.
- REQ-010: start  input  1  is a one-cycle pulse that SHALL begin one frame.
- REQ-011: i_valid  input  1  SHALL indicate that i_pixel is valid.
- REQ-012: i_ready  output  1  SHALL equal (fifo_count < FIFO_DEPTH), decoded combinationally from registered state.
- REQ-013: i_pixel  input  24  SHALL carry {R[23:16], G[15:8], B[7:0]}.
- REQ-014: ctrl_vsync  output  1  SHALL be the frame-start indicator.
- REQ-015: hsync  output  1  SHALL qualify each output beat.
- REQ-016: DATA_R0, DATA_G0, DATA_B0  output  8 each  SHALL carry the processed pixel.
- REQ-017: ctrl_done  output  1  SHALL pulse high for one cycle at frame end.

Function
- REQ-018: Input transfer SHALL occur when i_valid && i_ready. The FIFO SHALL be circular with wrapping pointers. When full, input SHALL be refused, even if a pop occurs in the same cycle.
- REQ-019: A push and a pop in the same cycle SHALL leave fifo_count unchanged. A pop SHALL never occur when the FIFO is empty.
- REQ-020: The FSM states SHALL be IDLE, VSYNC, HGAP, DATA and DONE.
- REQ-021: In IDLE, start=1 SHALL move the FSM to VSYNC. A start pulse in any other state SHALL be ignored.
- REQ-022: In VSYNC, ctrl_vsync SHALL be 1 for exactly VS_DELAY cycles, after which the FSM SHALL move to HGAP.
- REQ-023: In HGAP, the FSM SHALL wait exactly HS_GAP cycles, then move to DATA. hsync SHALL be 0 throughout.
- REQ-024: In DATA, each cycle in which the FIFO is non-empty SHALL pop one pixel and increment the column counter. Empty cycles SHALL stall, with no pop and no count.
- REQ-025: The processed pixel SHALL appear on the DATA_* outputs one cycle after its pop, with hsync=1 in that same cycle. In stall cycles hsync SHALL be 0 and DATA_* SHALL hold their last values.
- REQ-026: After WIDTH/2 pops, the column counter SHALL clear to 0. If row == HEIGHT-1, the FSM SHALL move to DONE; otherwise row SHALL increment and the FSM SHALL move to HGAP.
- REQ-027: DONE SHALL last one cycle, assert ctrl_done for that cycle, clear row, and return to IDLE. The last hsync beat SHALL occur in the same cycle as ctrl_done.
- REQ-028: Mode 1 SHALL compute each channel as min(ch+VALUE, 255) using a 9-bit intermediate.
- REQ-029: Mode 2 SHALL compute each channel as max(ch-VALUE, 0), detected by borrow.
- REQ-030: Mode 3 SHALL compute each channel as 255-ch. Mode 0 SHALL pass the channel through unchanged.
- REQ-031: Pixels left in the FIFO at frame end SHALL be retained for the next frame.

Reset
- REQ-032: While HRESETn=0, the state SHALL be IDLE, all counters 0, and the FIFO empty.
- REQ-033: While HRESETn=0, ctrl_vsync, hsync, ctrl_done and DATA_* SHALL all be 0, and i_ready SHALL be 1.
- REQ-034: Reset asserted mid-frame SHALL abort the frame immediately. No ctrl_done SHALL be issued and buffered pixels SHALL be discarded.

Verification
(All scenarios use WIDTH=4, HEIGHT=2, VS_DELAY=3, HS_GAP=2 unless stated otherwise.)
- REQ-035: Full frame, MODE=1, VALUE=100, input always valid with pixels 0x0A1432, 0xC8FA00 repeating -> ctrl_vsync high 3 cycles, 4 hsync beats of 0x6E7896, 0xFFFF64 alternating, ctrl_done exactly once, coincident with the 4th beat.
- REQ-036: MODE=2, VALUE=100, pixel 0x50C864 -> output R=0x00, G=0x64, B=0x00.
- REQ-037: MODE=3, pixel 0x00FF5A -> output 0xFF00A5. MODE=0, pixel 0x123456 -> output 0x123456 unchanged.
- REQ-038: Upstream starved for 5 cycles in mid-line -> hsync=0 and DATA_* held for those cycles, no beat lost, total 4 beats per frame.
- REQ-039: FIFO_DEPTH=4, start never issued, 6 valid pushes offered -> i_ready drops after 4 accepted, 2 refused; after start, the first 4 outputs are the accepted pixels in order.
- REQ-040: Reset pulsed during DATA of row 0 -> all outputs 0 and i_ready=1 asynchronously, no ctrl_done; a following start produces a clean full frame.

Source files
------------

// File: rtl/image_stream_proc.sv
// Streaming pixel processor: buffers 24-bit RGB input in a small circular FIFO and
// emits one frame of vsync / line-gap / data beats with a per-channel colour operation.
module image_stream_proc #(
   parameter int         WIDTH      = 960,
   parameter int         HEIGHT     = 540,
   parameter int         VS_DELAY   = 100,
   parameter int         HS_GAP     = 160,
   parameter logic [1:0] MODE       = 2'd1,
   parameter logic [7:0] VALUE      = 8'd100,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        start,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [23:0] i_pixel,
   output logic        ctrl_vsync,
   output logic        hsync,
   output logic [7:0]  DATA_R0,
   output logic [7:0]  DATA_G0,
   output logic [7:0]  DATA_B0,
   output logic        ctrl_done
);

   localparam int BEATS   = WIDTH / 2;
   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (VS_DELAY > HS_GAP) ? VS_DELAY : HS_GAP;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int COLW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ROWW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_VSYNC = 3'd1,
      S_HGAP  = 3'd2,
      S_DATA  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [COLW-1:0] col_q, col_d;
   logic [ROWW-1:0] row_q, row_d;
   logic            vsync_q, vsync_d;
   logic            hsync_q, hsync_d;
   logic            done_q, done_d;
   logic [23:0]     pix_q, pix_d;

   logic [23:0]     mem_q [FIFO_DEPTH];
   logic [23:0]     mem_d [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic            push_s, pop_s;

   function automatic logic [7:0] proc_ch(input logic [7:0] ch);
      logic [8:0] sum;
      logic [8:0] diff;
      logic [7:0] res;
      sum  = {1'b0, ch} + {1'b0, VALUE};
      diff = {1'b0, ch} - {1'b0, VALUE};
      case (MODE)
         2'd0:    res = ch;
         2'd1:    res = sum[8] ? 8'hFF : sum[7:0];
         2'd2:    res = diff[8] ? 8'h00 : diff[7:0];
         2'd3:    res = 8'hFF - ch;
         default: res = ch;
      endcase
      return res;
   endfunction

   // Full FIFO refuses input regardless of a same-cycle pop.
   assign i_ready = (count_q < (PW + 1)'(FIFO_DEPTH));
   assign push_s  = i_valid && i_ready;
   assign pop_s   = (state_q == S_DATA) && (count_q != {(PW + 1){1'b0}});

   // FIFO pointer, occupancy and storage next-state
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = i_pixel;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (PW + 1)'(1);
         2'b01:   count_d = count_q - (PW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 24'h000000;
         end
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {(PW + 1){1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Frame sequencing: next state, counters and output values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      row_d   = row_q;
      hsync_d = 1'b0;
      pix_d   = pix_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_VSYNC;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_VSYNC: begin
            if (cnt_q == CW'(VS_DELAY - 1)) begin
               state_d = S_HGAP;
               cnt_d   = {CW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HGAP: begin
            if (cnt_q == CW'(HS_GAP - 1)) begin
               state_d = S_DATA;
               cnt_d   = {CW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (pop_s) begin
               hsync_d = 1'b1;
               pix_d   = {proc_ch(mem_q[rd_ptr_q][23:16]),
                          proc_ch(mem_q[rd_ptr_q][15:8]),
                          proc_ch(mem_q[rd_ptr_q][7:0])};
               if (col_q == COLW'(BEATS - 1)) begin
                  col_d = {COLW{1'b0}};
                  if (row_q == ROWW'(HEIGHT - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     row_d   = row_q + ROWW'(1);
                     state_d = S_HGAP;
                     cnt_d   = {CW{1'b0}};
                  end
               end else begin
                  col_d = col_q + COLW'(1);
               end
            end else begin
               hsync_d = 1'b0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            row_d   = {ROWW{1'b0}};
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      vsync_d = (state_d == S_VSYNC);
      done_d  = (state_d == S_DONE);
   end

   // Frame FSM with registered outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         col_q   <= {COLW{1'b0}};
         row_q   <= {ROWW{1'b0}};
         vsync_q <= 1'b0;
         hsync_q <= 1'b0;
         done_q  <= 1'b0;
         pix_q   <= 24'h000000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
         vsync_q <= vsync_d;
         hsync_q <= hsync_d;
         done_q  <= done_d;
         pix_q   <= pix_d;
      end
   end

   assign ctrl_vsync = vsync_q;
   assign hsync      = hsync_q;
   assign ctrl_done  = done_q;
   assign DATA_R0    = pix_q[23:16];
   assign DATA_G0    = pix_q[15:8];
   assign DATA_B0    = pix_q[7:0];

endmodule

// File: tb/tb_image_stream_proc.sv
// Bench for image_stream_proc: four instances (one per MODE) share stimulus and are
// compared every cycle against a frame-level reference model of queue + timeline.
module tb_image_stream_proc;
   localparam int W = 4, H = 2, VS = 3, HS = 2, VAL = 100, DEPTH = 4;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, i_valid = 1'b0;
   logic [23:0] i_pixel = 24'h0;
   logic [3:0] rdy, vsy, hs, dn;
   logic [3:0][7:0] dr, dg, db;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      image_stream_proc #(.WIDTH(W), .HEIGHT(H), .VS_DELAY(VS), .HS_GAP(HS),
                          .MODE(2'(g)), .VALUE(8'(VAL)), .FIFO_DEPTH(DEPTH)) u_dut (
         .HCLK(clk), .HRESETn(rst_n), .start(start), .i_valid(i_valid), .i_ready(rdy[g]),
         .i_pixel(i_pixel), .ctrl_vsync(vsy[g]), .hsync(hs[g]), .DATA_R0(dr[g]),
         .DATA_G0(dg[g]), .DATA_B0(db[g]), .ctrl_done(dn[g]));
   end

   // Reference model: pixel queue plus frame phase (0 idle,1 vsync,2 gap,3 data,4 done)
   logic [23:0] mq[$];
   int m_ph = 0, m_left = 0, m_col = 0, m_row = 0;
   logic e_vs = 1'b0, e_hs = 1'b0, e_dn = 1'b0;
   logic [23:0] e_out[4];

   function automatic logic [23:0] proc(int mode, logic [23:0] px);
      logic [23:0] r;
      int ch, o;
      r = 24'h0;
      for (int k = 0; k < 3; k++) begin
         ch = int'(px[k*8 +: 8]);
         case (mode)
            1: o = (ch + VAL > 255) ? 255 : ch + VAL;
            2: o = (ch < VAL) ? 0 : ch - VAL;
            3: o = 255 - ch;
            default: o = ch;
         endcase
         r[k*8 +: 8] = 8'(o);
      end
      return r;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_ph = 0; m_left = 0; m_col = 0; m_row = 0;
      e_vs = 1'b0; e_hs = 1'b0; e_dn = 1'b0;
      for (int m = 0; m < 4; m++) e_out[m] = 24'h0;
   endtask

   task automatic step(input logic v, input logic [23:0] px, input logic st);
      logic pop, push;
      logic [23:0] head;
      i_valid = v; i_pixel = px; start = st;
      @(posedge clk);
      if (rst_n) begin
         pop  = (m_ph == 3) && (mq.size() > 0);
         push = v && (mq.size() < DEPTH);
         e_hs = pop;
         if (pop) begin
            head = mq.pop_front();
            for (int m = 0; m < 4; m++) e_out[m] = proc(m, head);
         end
         if (push) mq.push_back(px);
         case (m_ph)
            0: if (st) begin m_ph = 1; m_left = VS; end
            1: begin m_left--; if (m_left == 0) begin m_ph = 2; m_left = HS; end end
            2: begin m_left--; if (m_left == 0) m_ph = 3; end
            3: if (pop) begin
                  m_col++;
                  if (m_col == W / 2) begin
                     m_col = 0;
                     if (m_row == H - 1) m_ph = 4;
                     else begin m_row++; m_ph = 2; m_left = HS; end
                  end
               end
            default: begin m_ph = 0; m_row = 0; end
         endcase
         e_vs = (m_ph == 1);
         e_dn = (m_ph == 4);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      i_valid = 1'b0; start = 1'b0;
      rst_n = 1'b0; model_clear();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; model_clear();
      repeat (2) @(negedge clk);
      for (int m = 0; m < 4; m++) begin
         total++;
         if ({vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]} !== {4'b0001, 24'h0}) begin
            bad++; $display("FAIL reset mode%0d got=%h want=%h", m,
                            {vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]}, {4'b0001, 24'h0});
         end
      end
      rst_n = 1'b1;
      repeat (3) begin
         step(1'b0, 24'h0, 1'b0);
         for (int m = 0; m < 4; m++) begin
            total++;
            if ({vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]} !== {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]}) begin
               bad++; $display("FAIL idle mode%0d got=%h want=%h", m,
                               {vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]}, {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]});
            end
         end
      end
   endtask

   task automatic test_full_frame();
      logic [23:0] pat[2];
      int k = 0, vs_n = 0, beats = 0, dones = 0, done_last = 0, fin = 0;
      logic acc;
      pat[0] = 24'h0A1432; pat[1] = 24'hC8FA00;
      for (int c = 0; c < 100 && fin == 0; c++) begin
         acc = (mq.size() < DEPTH);
         step(1'b1, pat[k % 2], c == 0);
         if (acc) k++;
         for (int m = 0; m < 4; m++) begin
            total++;
            if ({vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]} !== {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]}) begin
               bad++; $display("FAIL frame mode%0d t=%0t got=%h want=%h", m, $time,
                               {vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]}, {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]});
            end
         end
         if (vsy[1]) vs_n++;
         if (hs[1]) begin
            total++;
            if ({dr[1], dg[1], db[1]} !== ((beats % 2 == 0) ? 24'h6E7896 : 24'hFFFF64)) begin
               bad++; $display("FAIL frame_beat%0d got=%h want=%h", beats, {dr[1], dg[1], db[1]},
                               (beats % 2 == 0) ? 24'h6E7896 : 24'hFFFF64);
            end
            beats++;
         end
         if (dn[1]) begin dones++; if (hs[1] && beats == 4) done_last++; end
         if (m_ph == 0) fin = 1;
      end
      total += 5;
      if (fin != 1) begin bad++; $display("FAIL frame_timeout got=%0d want=1", fin); end
      if (vs_n != VS) begin bad++; $display("FAIL vsync_len got=%0d want=%0d", vs_n, VS); end
      if (beats != 4) begin bad++; $display("FAIL beat_count got=%0d want=4", beats); end
      if (dones != 1) begin bad++; $display("FAIL done_count got=%0d want=1", dones); end
      if (done_last != 1) begin bad++; $display("FAIL done_with_last_beat got=%0d want=1", done_last); end
   endtask

   task automatic test_modes();
      logic [23:0] pl[4];
      int idx = 0, beats = 0, fin = 0;
      logic acc;
      pl[0] = 24'h50C864; pl[1] = 24'h00FF5A; pl[2] = 24'h123456; pl[3] = 24'h50C864;
      do_reset();
      for (int c = 0; c < 100 && fin == 0; c++) begin
         acc = (mq.size() < DEPTH) && (idx < 4);
         step(idx < 4, pl[idx % 4], c == 0);
         if (acc) idx++;
         for (int m = 0; m < 4; m++) begin
            total++;
            if ({vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]} !== {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]}) begin
               bad++; $display("FAIL modes mode%0d t=%0t got=%h want=%h", m, $time,
                               {vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]}, {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]});
            end
         end
         if (hs[0]) begin
            total++;
            case (beats)
               0: if ({dr[2], dg[2], db[2], dr[1], dg[1], db[1]} !== {24'h006400, 24'hB4FFC8}) begin
                     bad++; $display("FAIL sat_sub_add got=%h want=%h", {dr[2], dg[2], db[2], dr[1], dg[1], db[1]}, {24'h006400, 24'hB4FFC8});
                  end
               1: if ({dr[3], dg[3], db[3]} !== 24'hFF00A5) begin
                     bad++; $display("FAIL invert got=%h want=%h", {dr[3], dg[3], db[3]}, 24'hFF00A5);
                  end
               2: if ({dr[0], dg[0], db[0]} !== 24'h123456) begin
                     bad++; $display("FAIL passthru got=%h want=%h", {dr[0], dg[0], db[0]}, 24'h123456);
                  end
               default: if ({dr[2], dg[2], db[2]} !== 24'h006400) begin
                     bad++; $display("FAIL sat_sub_last got=%h want=%h", {dr[2], dg[2], db[2]}, 24'h006400);
                  end
            endcase
            beats++;
         end
         if (m_ph == 0) fin = 1;
      end
      total++;
      if (beats != 4) begin bad++; $display("FAIL modes_beats got=%0d want=4", beats); end
   endtask

   task automatic test_starve();
      int beats = 0, stall = 0, dones = 0, fin = 0;
      logic v;
      do_reset();
      for (int c = 0; c < 100 && fin == 0; c++) begin
         v = (c == 5) || (c >= 11);
         step(v, 24'($urandom), c == 0);
         for (int m = 0; m < 4; m++) begin
            total++;
            if ({vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]} !== {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]}) begin
               bad++; $display("FAIL starve mode%0d t=%0t got=%h want=%h", m, $time,
                               {vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]}, {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]});
            end
         end
         if (hs[0]) beats++;
         else if (beats == 1) stall++;
         if (dn[0]) dones++;
         if (m_ph == 0) fin = 1;
      end
      total += 3;
      if (stall != 5) begin bad++; $display("FAIL starve_gap got=%0d want=5", stall); end
      if (beats != 4) begin bad++; $display("FAIL starve_beats got=%0d want=4", beats); end
      if (dones != 1) begin bad++; $display("FAIL starve_done got=%0d want=1", dones); end
   endtask

   task automatic test_fifo_fill();
      logic [23:0] px[6];
      logic [23:0] got[$];
      int fin = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         px[i] = 24'($urandom);
         step(1'b1, px[i], 1'b0);
         for (int m = 0; m < 4; m++) begin
            total++;
            if ({vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]} !== {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]}) begin
               bad++; $display("FAIL fill mode%0d i=%0d got=%h want=%h", m, i,
                               {vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]}, {e_vs, e_hs, e_dn, mq.size() < DEPTH, e_out[m]});
            end
         end
      end
      total++;
      if (rdy[0] !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", rdy[0]); end
      for (int c = 0; c < 100 && fin == 0; c++) begin
         step(1'b0, 24'h0, c == 0);
         if (hs[0]) got.push_back({dr[0], dg[0], db[0]});
         if (m_ph == 0) fin = 1;
      end
      total++;
      if (got.size() != 4) begin bad++; $display("FAIL fill_beats got=%0d want=4", got.size()); end
      for (int k = 0; k < 4 && k < got.size(); k++) begin
         total++;
         if (got[k] !== px[k]) begin bad++; $display("FAIL fill_order%0d got=%h want=%h", k, got[k], px[k]); end
      end
   endtask

   task automatic test_reset_mid();
      int hit = 0;
      do_reset();
      for (int c = 0; c < 100 && hit == 0; c++) begin
         step(1'b1, 24'($urandom), c == 0);
         if (e_hs && m_row == 0) hit = 1;
      end
      total++;
      if (hit != 1) begin bad++; $display("FAIL midreset_reach got=%0d want=1", hit); end
      #2 rst_n = 1'b0;
      #1;
      for (int m = 0; m < 4; m++) begin
         total++;
         if ({vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]} !== {4'b0001, 24'h0}) begin
            bad++; $display("FAIL midreset_async mode%0d got=%h want=%h", m,
                            {vsy[m], hs[m], dn[m], rdy[m], dr[m], dg[m], db[m]}, {4'b0001, 24'h0});
         end
      end
      model_clear();
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 24'h0, 1'b0);
         total++;
         if (dn !== 4'b0000) begin bad++; $display("FAIL midreset_done got=%b want=0000", dn); end
      end
      rst_n = 1'b1;
      test_full_frame();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_full_frame();
      test_modes();
      test_starve();
      test_fifo_fill();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
